// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video timing generator.
// Holds the 640x480@60 segment lengths, the sync polarity encoding and a
// helper that applies a polarity to a raw in-pulse flag.
package video_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE      = 640;
    localparam int unsigned VGA_H_FRONT_PORCH = 16;
    localparam int unsigned VGA_H_SYNC_PULSE  = 96;
    localparam int unsigned VGA_H_BACK_PORCH  = 48;
    localparam int unsigned VGA_V_ACTIVE      = 480;
    localparam int unsigned VGA_V_FRONT_PORCH = 10;
    localparam int unsigned VGA_V_SYNC_PULSE  = 2;
    localparam int unsigned VGA_V_BACK_PORCH  = 33;
    localparam int unsigned VGA_CNT_W         = 10;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Active level equals the polarity bit; inactive level is its inverse.
    function automatic logic sync_level(input sync_pol_e pol, input logic raw);
        return raw ~^ logic'(pol);
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One axis (horizontal or vertical) of the video timing generator.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : advance the count by one (wraps at ACTIVE+FP+SP+BP-1)
//   wrap_o        : high when this enabled cycle wraps the count to 0
//   count_o       : registered count value
//   next_o        : next-state count, for zero-lag decode in the parent
//   pulse_o       : registered raw in-sync-pulse flag, decoded from next_o
module timing_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SP     = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned W      = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic         wrap_o,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_o,
    output logic         pulse_o
);

    localparam int unsigned TOTAL      = ACTIVE + FP + SP + BP;
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = ACTIVE + FP + SP;

    if (ACTIVE == 0 || FP == 0 || SP == 0 || BP == 0 ||
        longint'(TOTAL) > (longint'(1) << W)) begin : g_bad_cfg
        $error("timing_axis_counter: zero segment or total exceeds counter range");
    end

    logic [W-1:0] count_q, count_d;
    logic         pulse_q, pulse_d;

    always_comb begin
        wrap_o  = en_i && (count_q == W'(TOTAL - 1));
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
        pulse_d = (count_d >= W'(SYNC_START)) && (count_d < W'(SYNC_END));
    end

    // Pulse only refreshes on an advance, so it never moves without the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else if (en_i) begin
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, data-enable and
// line/frame start strobes, all registered and aligned to the counters.
// Ports:
//   i_clk, i_rst_n : pixel clock, asynchronous active-low reset
//   i_pixEn        : pixel advance enable
//   o_hCount/o_vCount : current column / line
//   o_hsync/o_vsync   : polarity-applied sync
//   o_de              : visible-region flag
//   o_lineStart/o_frameStart : one-cycle strobes at column 0 / pixel (0,0)
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT_PORCH = VGA_H_FRONT_PORCH,
    parameter int unsigned H_SYNC_PULSE  = VGA_H_SYNC_PULSE,
    parameter int unsigned H_BACK_PORCH  = VGA_H_BACK_PORCH,
    parameter int unsigned V_ACTIVE      = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT_PORCH = VGA_V_FRONT_PORCH,
    parameter int unsigned V_SYNC_PULSE  = VGA_V_SYNC_PULSE,
    parameter int unsigned V_BACK_PORCH  = VGA_V_BACK_PORCH,
    parameter bit          H_POLARITY    = 1'b0,
    parameter bit          V_POLARITY    = 1'b0,
    parameter int unsigned CNT_W         = VGA_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pixEn,
    output logic [CNT_W-1:0] o_hCount,
    output logic [CNT_W-1:0] o_vCount,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic             o_lineStart,
    output logic             o_frameStart
);

    localparam sync_pol_e H_POL = sync_pol_e'(H_POLARITY);
    localparam sync_pol_e V_POL = sync_pol_e'(V_POLARITY);

    logic             h_wrap, v_wrap;
    logic [CNT_W-1:0] h_next, v_next;
    logic             h_pulse, v_pulse;
    logic             de_q, de_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FRONT_PORCH),
        .SP     (H_SYNC_PULSE),
        .BP     (H_BACK_PORCH),
        .W      (CNT_W)
    ) u_h_axis (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .en_i    (i_pixEn),
        .wrap_o  (h_wrap),
        .count_o (o_hCount),
        .next_o  (h_next),
        .pulse_o (h_pulse)
    );

    // Lines advance only on the cycle the column counter wraps.
    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FRONT_PORCH),
        .SP     (V_SYNC_PULSE),
        .BP     (V_BACK_PORCH),
        .W      (CNT_W)
    ) u_v_axis (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .en_i    (h_wrap),
        .wrap_o  (v_wrap),
        .count_o (o_vCount),
        .next_o  (v_next),
        .pulse_o (v_pulse)
    );

    always_comb begin
        de_d    = (h_next < CNT_W'(H_ACTIVE)) && (v_next < CNT_W'(V_ACTIVE));
        line_d  = h_wrap;
        frame_d = h_wrap && v_wrap;
    end

    // Strobes clear on any disabled cycle; de holds with the counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            frame_q <= frame_d;
            if (i_pixEn) begin
                de_q <= de_d;
            end
        end
    end

    assign o_de         = de_q;
    assign o_lineStart  = line_q;
    assign o_frameStart = frame_q;
    assign o_hsync      = sync_level(H_POL, h_pulse);
    assign o_vsync      = sync_level(V_POL, v_pulse);

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameters H_FRONT_PORCH 16, H_SYNC_PULSE 96 and H_BACK_PORCH 48, giving horizontal blanking segment lengths in pixels.
REQ-003 The module SHALL have parameters V_ACTIVE 480, V_FRONT_PORCH 10, V_SYNC_PULSE 2 and V_BACK_PORCH 33, giving vertical segment lengths in lines.
REQ-004 The module SHALL have parameters H_POLARITY 0 and V_POLARITY 0, where 0 means the sync is low during its pulse and 1 means it is high.
REQ-005 The module SHALL have parameter CNT_W, default 10, the width of both counters.
REQ-006 The ports SHALL be, in order:
- i_clk  in  1  pixel-domain clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixEn  in  1  pixel advance enable.
- o_hCount  out  CNT_W  current pixel column.
- o_vCount  out  CNT_W  current line.
- o_hsync  out  1  horizontal sync, polarity-applied.
- o_vsync  out  1  vertical sync, polarity-applied.
- o_de  out  1  high in the visible region.
- o_lineStart  out  1  one-cycle pulse at column 0.
- o_frameStart  out  1  one-cycle pulse at column 0, line 0.

Function
REQ-007 H_TOTAL SHALL be H_ACTIVE+H_FRONT_PORCH+H_SYNC_PULSE+H_BACK_PORCH, and V_TOTAL SHALL be the same sum of the V_ parameters.
REQ-008 Elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if any segment parameter is 0.
REQ-009 On each i_clk edge with i_pixEn=1, hCount SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-010 vCount SHALL increment only on the cycle hCount wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-011 With i_pixEn=0, counters and all outputs SHALL hold their values, except o_lineStart and o_frameStart, which SHALL be 0.
REQ-012 o_de SHALL be 1 iff hCount<H_ACTIVE and vCount<V_ACTIVE.
REQ-013 The raw horizontal pulse SHALL be active iff H_ACTIVE+H_FRONT_PORCH <= hCount < H_ACTIVE+H_FRONT_PORCH+H_SYNC_PULSE; the vertical rule SHALL be the same on vCount with the V_ parameters.
REQ-014 o_vsync SHALL change only together with a vCount change, and SHALL be independent of hCount.
REQ-015 o_hsync and o_vsync SHALL be the raw pulse when POLARITY=1 and its inverse when POLARITY=0.
REQ-016 o_lineStart SHALL be 1 for exactly one enabled cycle when hCount becomes 0; o_frameStart SHALL additionally require vCount to become 0.
REQ-017 All outputs SHALL be registers, decoded from next-state counter values, so they align with o_hCount/o_vCount in the same cycle with zero decode lag.
REQ-018 No combinational path SHALL exist from any input to any output.

Reset
REQ-019 While i_rst_n=0, hCount and vCount SHALL be 0, o_de 0, o_lineStart 0 and o_frameStart 0.
REQ-020 While i_rst_n=0, o_hsync SHALL be at its inactive level (~H_POLARITY) and o_vsync at ~V_POLARITY.
REQ-021 Reset assertion mid-frame SHALL take effect immediately, without a clock edge.
REQ-022 After release, the first enabled edge SHALL advance hCount to 1; the reset state itself represents pixel (0,0) with no start pulses.

Structure
REQ-023 Package video_timing_pkg SHALL hold the 640x480@60 default segment constants and a polarity enumeration (SYNC_ACTIVE_LOW=0, SYNC_ACTIVE_HIGH=1).
REQ-024 Sub-module timing_axis_counter SHALL be instantiated twice (H, V), with ports count enable, wrap output, count value and in-pulse output, and parameters ACTIVE, FP, SP, BP and W.

Verification
Small config for REQ-025 to REQ-028: H = 8/2/3/1 (H_TOTAL 14), V = 4/1/2/1 (V_TOTAL 8), CNT_W 4, polarities 0.
REQ-025 Reset then i_pixEn held 1 for 112 cycles -> o_hsync low exactly at hCount 10..12; o_vsync low exactly at vCount 5..6; o_de high for 32 cycles per frame; o_frameStart once, at cycle 112.
REQ-026 i_pixEn toggling 1,0,1,0 -> counters advance every other cycle; start pulses never last more than 1 cycle; the frame completes in 224 cycles.
REQ-027 Reset at hCount=9, vCount=3 -> outputs go immediately to 0/0, hsync=1, vsync=1, de=0; the restart is clean.
REQ-028 Same config with H_POLARITY=1 and V_POLARITY=1 -> sync waveforms are bit-inverted and the de trace is unchanged.
REQ-029 Default 640x480 run for 2 frames -> 800x525 periodicity; hsync low at hCount 656..751; vsync low at vCount 490..491.
